arith_pipe: RTL and testbench
=============================

Name: arith_pipe

Overview:
- Parametrised, pipelined integer arithmetic execution unit for the out-of-order core.
- Sits between the ALU reservation-station issue port and the common data bus (CDB) writeback arbiter.
- Generalises the single-cycle arithmetic unit:
  - configurable datapath width and pipeline depth;
  - valid/ready handshakes on both sides, with backpressure;
  - ROB-tag pass-through;
  - flush on mispredict;
  - correct LUI/AUIPC/JAL/JALR/SLT(I) result generation.

Parameters:
XLEN, 32, datapath width (32 or 64)
TAG_W, 6, ROB tag width
STAGES, 2, pipeline register stages from accept to writeback (legal range 1..4)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
flush_i  in  1  kill all in-flight ops (branch mispredict / exception)
req_valid_i  in  1  issue request valid
req_ready_o  out  1  unit can accept this cycle
pc_i  in  XLEN  instruction PC
inst_i  in  32  raw instruction
rs1_value_i  in  XLEN  operand 1
rs2_value_i  in  XLEN  operand 2
tag_i  in  TAG_W  ROB tag of request
wb_valid_o  out  1  result valid
wb_ready_i  in  1  CDB grant
wb_value_o  out  XLEN  result
wb_tag_o  out  TAG_W  ROB tag of result
wb_illegal_o  out  1  opcode/funct not supported; wb_value_o = 0
busy_o  out  1  any stage holds a valid op

Behaviour:
- Reset: applied asynchronously on reset_i high.
  - All stage valid bits clear.
  - wb_valid_o=0, wb_value_o=0, wb_tag_o=0, wb_illegal_o=0, busy_o=0.
  - req_ready_o=1 once reset deasserts.
- Accept: a request is accepted on a rising edge where req_valid_i & req_ready_o. Decode and ALU evaluation occur combinationally in stage 0; the result is registered into stage 1.
- Latency: exactly STAGES cycles from accept to wb_valid_o when unstalled. Throughput is 1 op/cycle.
- Elastic pipeline:
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage retires on wb_valid_o & wb_ready_i.
  - req_ready_o = !stage1_valid | stage1_advancing. It is combinational from wb_ready_i; no bubble is needed at full throughput.
- Output stability: while wb_valid_o=1 and wb_ready_i=0, wb_value_o, wb_tag_o and wb_illegal_o are held stable.
- Flush:
  - flush_i high clears every valid bit on the next edge.
  - A request presented in the same cycle as flush_i is not accepted (req_ready_o forced 0).
  - A retirement in the flush cycle still completes (the CDB already sampled it).
- Results:
  - OP-IMM/OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. The immediate forms use sign-extended imm_i.
  - SLT(I)/SLTU(I) compare rs1 with rs2 or imm_i (not shamt).
  - Shift amount = low log2(XLEN) bits of rs2 or imm. For XLEN=32 with imm[5]=1, the op is flagged illegal.
  - LUI: result = sign-extended imm_u.
  - AUIPC: result = pc_i + imm_u.
  - JAL/JALR: result = pc_i + 4 (link value).
- Arithmetic: all arithmetic is modulo 2^XLEN. SRA fills with operand bit XLEN-1.
- Illegal: an undefined funct7 or an unknown opcode still flows through the pipe with wb_illegal_o=1 and value 0, so the ROB can raise the exception.
- busy_o: OR of all stage valid bits.

Optional Feature:
- Macro: ARITH_PIPE_ZBA_EN.
- Defined: OP with funct7=0010000 decodes SH1ADD/SH2ADD/SH3ADD (funct3 010/100/110), giving result (rs1<<1|2|3)+rs2.
- Undefined: those encodings report wb_illegal_o=1.

Decomposition:
- Shared package arith_pkg holds:
  - opcode constants: OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR;
  - FUNCT3_*/FUNCT7_* constants;
  - the ALU_OP_* enum (4 bits);
  - the immediate-extraction functions.
- One sub-module, arith_decode: combinational, maps inst/pc/operands to {op1, op2, alu_func, illegal}.
- The existing combinational alu is instantiated for evaluation; the pipeline registers stay in arith_pipe.

Test Plan:
- ADDI x, rs1=5, imm=-3, tag=7, STAGES=2, wb_ready_i=1 -> wb_valid_o exactly 2 cycles later, value 2, tag 7.
- Back-to-back SUB 10-3, SRA 0x80000000>>4, SLTIU 1<imm 0xFFF -> three consecutive writeback cycles with values 7, 0xF8000000, 1.
- Hold wb_ready_i=0 while issuing 3 ops with STAGES=2:
  - req_ready_o drops after the pipe fills (2 ops held);
  - wb_value_o stays stable;
  - releasing wb_ready_i drains the ops in order with no loss or duplication.
- AUIPC pc=0x1000 imm_u=0x2000, then JALR pc=0x1000 -> values 0x3000 and 0x1004.
- flush_i asserted with 2 ops in flight plus req_valid_i=1 -> no writeback for any of the 3 ops; busy_o=0 the next cycle.
- funct7=0010000, funct3=010, rs1=3, rs2=1 -> value 7 with ARITH_PIPE_ZBA_EN defined; wb_illegal_o=1 and value 0 without it. Assert reset_i mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: opcode/funct constants, ALU operation encoding and
// immediate-extraction helpers shared by the arithmetic pipe.
package arith_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_SH1ADD  = 3'b010;
  localparam logic [2:0] FUNCT3_SH2ADD  = 3'b100;
  localparam logic [2:0] FUNCT3_SH3ADD  = 3'b110;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_ZBA  = 7'b0010000;

  typedef enum logic [3:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
    ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
    ALU_OP_SH1ADD, ALU_OP_SH2ADD, ALU_OP_SH3ADD
  } alu_op_e;

  // 32-bit sign-extended I-immediate; callers widen to XLEN
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  // 32-bit U-immediate (upper 20 bits, low 12 zero)
  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/arith_alu.sv
// alu: combinational integer ALU, all arithmetic modulo 2^XLEN.
module alu
  import arith_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  alu_op_e         func,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = op_b[SHW-1:0];

  // evaluate the selected function
  always_comb begin
    result = '0;
    case (func)
      ALU_OP_ADD:    result = op_a + op_b;
      ALU_OP_SUB:    result = op_a - op_b;
      ALU_OP_SLL:    result = op_a << shamt;
      ALU_OP_SLT:    result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_OP_SLTU:   result = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_OP_XOR:    result = op_a ^ op_b;
      ALU_OP_SRL:    result = op_a >> shamt;
      ALU_OP_SRA:    result = $signed(op_a) >>> shamt;
      ALU_OP_OR:     result = op_a | op_b;
      ALU_OP_AND:    result = op_a & op_b;
      ALU_OP_SH1ADD: result = (op_a << 1) + op_b;
      ALU_OP_SH2ADD: result = (op_a << 2) + op_b;
      ALU_OP_SH3ADD: result = (op_a << 3) + op_b;
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/arith_decode.sv
// arith_decode: maps instruction/pc/operands onto ALU operands and function.
// Optional build macro: ARITH_PIPE_ZBA_EN enables SH1ADD/SH2ADD/SH3ADD.
module arith_decode
  import arith_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output alu_op_e         alu_func,
  output logic            illegal
);

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [5:0]        funct6;
  logic signed [31:0] imm_i_s, imm_u_s;
  logic [XLEN-1:0]   imm_i_x, imm_u_x;
  logic              shimm_ok;
  logic              unused_reg_fields;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign funct6  = inst[31:26];
  assign imm_i_s = imm_i(inst);
  assign imm_u_s = imm_u(inst);
  assign imm_i_x = XLEN'(imm_i_s);
  assign imm_u_x = XLEN'(imm_u_s);
  // shamt bit 5 only exists on a 64-bit datapath
  assign shimm_ok = (XLEN == 64) ? 1'b1 : !inst[25];
  // register indices are resolved upstream by rename
  assign unused_reg_fields = ^{inst[19:15], inst[11:7]};

  // decode opcode/funct into operand selection and ALU function
  always_comb begin
    op1      = rs1_value;
    op2      = rs2_value;
    alu_func = ALU_OP_ADD;
    illegal  = 1'b0;
    case (opcode)
      OP_LUI: begin
        op1 = '0;
        op2 = imm_u_x;
      end
      OP_AUIPC: begin
        op1 = pc;
        op2 = imm_u_x;
      end
      OP_JAL, OP_JALR: begin
        op1 = pc;
        op2 = XLEN'(4);
      end
      OP_OP_IMM: begin
        op2 = imm_i_x;
        case (funct3)
          FUNCT3_ADD_SUB: alu_func = ALU_OP_ADD;
          FUNCT3_SLT:     alu_func = ALU_OP_SLT;
          FUNCT3_SLTU:    alu_func = ALU_OP_SLTU;
          FUNCT3_XOR:     alu_func = ALU_OP_XOR;
          FUNCT3_OR:      alu_func = ALU_OP_OR;
          FUNCT3_AND:     alu_func = ALU_OP_AND;
          FUNCT3_SLL: begin
            alu_func = ALU_OP_SLL;
            illegal  = (funct6 != 6'b000000) || !shimm_ok;
          end
          FUNCT3_SRL_SRA: begin
            if (funct6 == 6'b000000)      alu_func = ALU_OP_SRL;
            else if (funct6 == 6'b010000) alu_func = ALU_OP_SRA;
            else                          illegal  = 1'b1;
            if (!shimm_ok) illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_OP: begin
        case (funct7)
          FUNCT7_BASE: begin
            case (funct3)
              FUNCT3_ADD_SUB: alu_func = ALU_OP_ADD;
              FUNCT3_SLL:     alu_func = ALU_OP_SLL;
              FUNCT3_SLT:     alu_func = ALU_OP_SLT;
              FUNCT3_SLTU:    alu_func = ALU_OP_SLTU;
              FUNCT3_XOR:     alu_func = ALU_OP_XOR;
              FUNCT3_SRL_SRA: alu_func = ALU_OP_SRL;
              FUNCT3_OR:      alu_func = ALU_OP_OR;
              FUNCT3_AND:     alu_func = ALU_OP_AND;
              default:        illegal  = 1'b1;
            endcase
          end
          FUNCT7_ALT: begin
            case (funct3)
              FUNCT3_ADD_SUB: alu_func = ALU_OP_SUB;
              FUNCT3_SRL_SRA: alu_func = ALU_OP_SRA;
              default:        illegal  = 1'b1;
            endcase
          end
`ifdef ARITH_PIPE_ZBA_EN
          FUNCT7_ZBA: begin
            case (funct3)
              FUNCT3_SH1ADD: alu_func = ALU_OP_SH1ADD;
              FUNCT3_SH2ADD: alu_func = ALU_OP_SH2ADD;
              FUNCT3_SH3ADD: alu_func = ALU_OP_SH3ADD;
              default:       illegal  = 1'b1;
            endcase
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/arith_pipe.sv
// arith_pipe: elastic pipelined integer execution unit between RS issue
// and CDB writeback. Optional build macro: ARITH_PIPE_ZBA_EN.
module arith_pipe
  import arith_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  rs1_value_i,
  input  logic [XLEN-1:0]  rs2_value_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [XLEN-1:0]  wb_value_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             wb_illegal_o,
  output logic             busy_o
);

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } wb_t;

  logic [XLEN-1:0] op1, op2, alu_res;
  alu_op_e         alu_func;
  logic            dec_illegal;
  logic            accept;
  wb_t             stg0;
  wb_t             stg_q [STAGES:1];
  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] space;

  arith_decode #(.XLEN(XLEN)) u_decode (
    .pc        (pc_i),
    .inst      (inst_i),
    .rs1_value (rs1_value_i),
    .rs2_value (rs2_value_i),
    .op1       (op1),
    .op2       (op2),
    .alu_func  (alu_func),
    .illegal   (dec_illegal)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .op_a   (op1),
    .op_b   (op2),
    .func   (alu_func),
    .result (alu_res)
  );

  // stage 0 payload; illegal ops carry a zero value to the ROB
  always_comb begin
    stg0.value   = dec_illegal ? '0 : alu_res;
    stg0.tag     = tag_i;
    stg0.illegal = dec_illegal;
  end

  // stage k can load when some stage at or after k is empty, or the CDB
  // grants; bubbles ahead of k always collapse in the same edge
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      logic full;
      full = 1'b1;
      for (int j = k; j <= STAGES; j++) full = full & vld_pipe[j];
      space[k] = wb_ready_i | !full;
    end
  end

  assign req_ready_o = space[1] & !flush_i;
  assign accept      = req_valid_i & req_ready_o;

  // pipeline registers; payload only moves with a valid op, so a stalled
  // output stage holds its value
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_pipe <= '0;
      for (int k = 1; k <= STAGES; k++) stg_q[k] <= '0;
    end else if (flush_i) begin
      vld_pipe <= '0;
    end else begin
      if (space[1]) begin
        vld_pipe[1] <= accept;
        if (accept) stg_q[1] <= stg0;
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (space[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) stg_q[k] <= stg_q[k-1];
        end
      end
    end
  end

  assign wb_valid_o   = vld_pipe[STAGES];
  assign wb_value_o   = stg_q[STAGES].value;
  assign wb_tag_o     = stg_q[STAGES].tag;
  assign wb_illegal_o = stg_q[STAGES].illegal;
  assign busy_o       = |vld_pipe;

endmodule

// File: tb/tb_arith_pipe.sv
// tb_arith_pipe: directed and randomized checks of arith_pipe against a
// queue-based reference model of the issue-to-writeback behaviour.
module tb_arith_pipe;
  localparam int XLEN = 32, TAG_W = 6, STAGES = 2;

  logic clk_i = 1'b0;
  logic reset_i, flush_i, req_valid_i, req_ready_o, wb_valid_o, wb_ready_i;
  logic wb_illegal_o, busy_o;
  logic [31:0] pc_i, inst_i, rs1_value_i, rs2_value_i, wb_value_o;
  logic [TAG_W-1:0] tag_i, wb_tag_o;

  int errors = 0, checks = 0;

  always #5 clk_i = ~clk_i;

  arith_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .rs1_value_i(rs1_value_i),
    .rs2_value_i(rs2_value_i), .tag_i(tag_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_value_o(wb_value_o), .wb_tag_o(wb_tag_o),
    .wb_illegal_o(wb_illegal_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm, 5'd1, f3, 5'd3, opc};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [6:0] opc);
    return {imm, 5'd3, opc};
  endfunction

  // reference result straight from the instruction semantics (RV32)
  function automatic void ref_exec(input logic [31:0] pc, input logic [31:0] inst,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] v, output logic ill);
    logic [31:0] ii, uu;
    logic [6:0] f7;
    logic [2:0] f3;
    ii = {{20{inst[31]}}, inst[31:20]};
    uu = {inst[31:12], 12'h000};
    f7 = inst[31:25];
    f3 = inst[14:12];
    v = 0;
    ill = 0;
    case (inst[6:0])
      7'h37: v = uu;
      7'h17: v = pc + uu;
      7'h6f, 7'h67: v = pc + 32'd4;
      7'h13: case (f3)
        3'd0: v = a + ii;
        3'd1: if (f7 == 7'h00) v = a << inst[24:20]; else ill = 1;
        3'd2: v = {31'b0, $signed(a) < $signed(ii)};
        3'd3: v = {31'b0, a < ii};
        3'd4: v = a ^ ii;
        3'd5: if (f7 == 7'h00) v = a >> inst[24:20];
              else if (f7 == 7'h20) v = $unsigned($signed(a) >>> inst[24:20]);
              else ill = 1;
        3'd6: v = a | ii;
        default: v = a & ii;
      endcase
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: v = a + b;
            3'd1: v = a << b[4:0];
            3'd2: v = {31'b0, $signed(a) < $signed(b)};
            3'd3: v = {31'b0, a < b};
            3'd4: v = a ^ b;
            3'd5: v = a >> b[4:0];
            3'd6: v = a | b;
            default: v = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) v = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) v = $unsigned($signed(a) >>> b[4:0]);
`ifdef ARITH_PIPE_ZBA_EN
        else if (f7 == 7'h10 && f3 == 3'd2) v = a * 2 + b;
        else if (f7 == 7'h10 && f3 == 3'd4) v = a * 4 + b;
        else if (f7 == 7'h10 && f3 == 3'd6) v = a * 8 + b;
`endif
        else ill = 1;
      end
      default: ill = 1;
    endcase
    if (ill) v = 0;
  endfunction

  // scoreboard: expected writebacks in issue order with accept time
  typedef struct { logic [31:0] v; logic [TAG_W-1:0] tag; logic ill; int t; } exp_t;
  exp_t q[$];
  int cyc = 0;
  bit mon_en = 0;
  bit exp_valid, exp_ready;

  // model: oldest op shows up STAGES cycles after accept, stays until granted;
  // the pipe holds at most STAGES ops
  always @(negedge clk_i) if (mon_en) begin
    cyc++;
    if (reset_i) q.delete();
    else begin
      exp_t e;
      exp_valid = (q.size() > 0) && (cyc - q[0].t >= STAGES);
      exp_ready = !flush_i && (q.size() < STAGES || (exp_valid && wb_ready_i));
      chk("req_ready", req_ready_o, exp_ready);
      chk("wb_valid", wb_valid_o, exp_valid);
      if (exp_valid) begin
        chk("wb_value", wb_value_o, q[0].v);
        chk("wb_tag", wb_tag_o, q[0].tag);
        chk("wb_illegal", wb_illegal_o, q[0].ill);
      end
      chk("busy", busy_o, q.size() > 0);
      if (exp_valid && wb_ready_i) void'(q.pop_front());
      if (flush_i) q.delete();
      else if (req_valid_i && exp_ready) begin
        ref_exec(pc_i, inst_i, rs1_value_i, rs2_value_i, e.v, e.ill);
        e.tag = tag_i;
        e.t = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic set_op(input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    req_valid_i = 1; pc_i = pc; inst_i = inst; rs1_value_i = a; rs2_value_i = b; tag_i = tag;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 15));
      2: return 32'h8000_0000;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic rand_op();
    logic [6:0] f7s [3];
    logic [31:0] inst;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;
    case ($urandom_range(0, 9))
      0: inst = enc_i(12'($urandom), 3'($urandom), 7'h13);
      1, 2: inst = enc_r(f7s[$urandom_range(0, 1)], 3'($urandom), 7'h33);
      3: inst = enc_r(7'h10, 3'($urandom), 7'h33);
      4: inst = enc_u(20'($urandom), 7'h37);
      5: inst = enc_u(20'($urandom), 7'h17);
      6: inst = enc_u(20'($urandom), 7'h6f);
      7: inst = enc_i(12'($urandom), 3'd0, 7'h67);
      8: inst = $urandom;
      default: inst = enc_i({f7s[$urandom_range(0, 2)], 5'($urandom)},
                            ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5, 7'h13);
    endcase
    set_op($urandom, inst, pick_val(), pick_val(), 6'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] zexp;
    logic zill;
    reset_i = 1; flush_i = 0; req_valid_i = 0; wb_ready_i = 1;
    pc_i = 0; inst_i = 0; rs1_value_i = 0; rs2_value_i = 0; tag_i = 0;
    step();
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_value", wb_value_o, 0);
    chk("rst_wb_tag", wb_tag_o, 0);
    chk("rst_wb_illegal", wb_illegal_o, 0);
    chk("rst_busy", busy_o, 0);
    step();
    reset_i = 0; mon_en = 1;
    #1 chk("ready_after_reset", req_ready_o, 1);

    // ADDI 5 + -3, tag 7: exactly STAGES cycles
    set_op(0, enc_i(12'hFFD, 3'd0, 7'h13), 5, 0, 7);
    step(); req_valid_i = 0;
    chk("addi_lat1_valid", wb_valid_o, 0);
    step();
    chk("addi_valid", wb_valid_o, 1);
    chk("addi_value", wb_value_o, 2);
    chk("addi_tag", wb_tag_o, 7);
    step();

    // back-to-back SUB, SRA, SLTIU
    set_op(0, enc_r(7'h20, 3'd0, 7'h33), 10, 3, 1); step();
    set_op(0, enc_r(7'h20, 3'd5, 7'h33), 32'h8000_0000, 4, 2); step();
    chk("b2b_sub", wb_value_o, 7);
    set_op(0, enc_i(12'hFFF, 3'd3, 7'h13), 1, 0, 3); step();
    req_valid_i = 0;
    chk("b2b_sra", wb_value_o, 32'hF800_0000);
    step();
    chk("b2b_sltiu", wb_value_o, 1);
    chk("b2b_sltiu_valid", wb_valid_o, 1);
    step();

    // backpressure: two ops fill the pipe, third waits
    wb_ready_i = 0;
    set_op(0, enc_r(7'h00, 3'd0, 7'h33), 32'h10, 32'h20, 11); step();
    set_op(0, enc_r(7'h00, 3'd4, 7'h33), 32'hF0, 32'h0F, 12); step();
    set_op(0, enc_r(7'h00, 3'd6, 7'h33), 32'h1, 32'h2, 13);
    #1 chk("stall_ready", req_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_value", wb_value_o, 32'h30);
      chk("stall_hold_tag", wb_tag_o, 11);
    end
    wb_ready_i = 1;
    #1 chk("release_ready", req_ready_o, 1);
    step(); req_valid_i = 0;
    repeat (4) step();

    // AUIPC then JALR
    set_op(32'h1000, enc_u(20'h2, 7'h17), 0, 0, 4); step();
    set_op(32'h1000, enc_i(12'h0, 3'd0, 7'h67), 0, 0, 5); step();
    req_valid_i = 0;
    chk("auipc", wb_value_o, 32'h3000);
    step();
    chk("jalr", wb_value_o, 32'h1004);
    step();

    // flush with two in flight plus a request
    wb_ready_i = 0;
    set_op(0, enc_i(12'h1, 3'd0, 7'h13), 1, 0, 21); step();
    set_op(0, enc_i(12'h2, 3'd0, 7'h13), 1, 0, 22); step();
    set_op(0, enc_i(12'h3, 3'd0, 7'h13), 1, 0, 23); flush_i = 1;
    #1 chk("flush_ready", req_ready_o, 0);
    step(); flush_i = 0; req_valid_i = 0; wb_ready_i = 1;
    chk("flush_busy", busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_wb", wb_valid_o, 0);
    end

    // SH1ADD encoding
    set_op(0, enc_r(7'h10, 3'd2, 7'h33), 3, 1, 9); step(); req_valid_i = 0; step();
`ifdef ARITH_PIPE_ZBA_EN
    zexp = 7; zill = 0;
`else
    zexp = 0; zill = 1;
`endif
    chk("zba_value", wb_value_o, zexp);
    chk("zba_illegal", wb_illegal_o, zill);
    step();

    // async reset in the middle of a stall
    wb_ready_i = 0;
    set_op(0, enc_i(12'h7, 3'd0, 7'h13), 1, 0, 31); step();
    set_op(0, enc_i(12'h8, 3'd0, 7'h13), 1, 0, 32); step();
    req_valid_i = 0; step();
    #2 reset_i = 1;
    #1;
    chk("mid_rst_valid", wb_valid_o, 0);
    chk("mid_rst_value", wb_value_o, 0);
    chk("mid_rst_tag", wb_tag_o, 0);
    chk("mid_rst_illegal", wb_illegal_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    @(negedge clk_i);
    step(); reset_i = 0; wb_ready_i = 1;
    #1 chk("ready_after_mid_rst", req_ready_o, 1);

    // randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      rand_op();
      req_valid_i = ($urandom_range(0, 9) < 7);
      wb_ready_i  = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 49) == 0);
      step();
    end
    req_valid_i = 0; flush_i = 0; wb_ready_i = 1;
    repeat (6) step();
    chk("drain_busy", busy_o, 0);
    chk("drain_model_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
